// File: rtl/stg5mo.sv
// stg5mo: memory-result stage. It selects load data from the memory port named by the port-phase bit and suppresses register writes for stores.
// Latency: 1 cycle from the stage inputs to the output registers when iw_hold=0 and the skid buffer is empty.
// Backpressure: iw_hold=1 stores the current instruction, including its load data, in a one-entry skid buffer. ow_hold is registered and stays high while the skid buffer is full.
//
// Ports:
//   iw_clk, iw_rst          clock and asynchronous active-high reset
//   iw_pc/instr/opc         pass-through instruction fields -> ow_pc/instr/opc
//   iw_tgt_gp[_we]          GP target and write enable -> ow_tgt_gp[_we] (write enable forced 0 for stores)
//   iw_tgt_sr[_we]          SR target and write enable -> ow_tgt_sr[_we] (write enable forced 0 for stores)
//   iw_mem_mp, iw_mem_data  memory port select and per-port read data (valid only in the arrival cycle)
//   iw_result -> ow_result  ALU result in, writeback value out (load data for loads)
//   iw_hold / ow_hold       stall request from downstream / stall request to upstream
//   ow_valid                output registers hold an instruction that has not been consumed
module stg5mo #(
  parameter int unsigned SIZE_ADDR   = 32,
  parameter int unsigned SIZE_DATA   = 32,
  parameter int unsigned SIZE_OPC    = 8,
  parameter int unsigned SIZE_TGT_GP = 4,
  parameter int unsigned SIZE_TGT_SR = 2,
  parameter logic [SIZE_OPC-1:0] OPC_RU_LDu  = 8'h21,
  parameter logic [SIZE_OPC-1:0] OPC_RU_STu  = 8'h22,
  parameter logic [SIZE_OPC-1:0] OPC_IU_STiu = 8'h32,
  parameter logic [SIZE_OPC-1:0] OPC_IS_STis = 8'h42
) (
  input  logic                   iw_clk,
  input  logic                   iw_rst,
  input  logic [SIZE_ADDR-1:0]   iw_pc,
  input  logic [SIZE_DATA-1:0]   iw_instr,
  input  logic [SIZE_OPC-1:0]    iw_opc,
  input  logic [SIZE_TGT_GP-1:0] iw_tgt_gp,
  input  logic                   iw_tgt_gp_we,
  input  logic [SIZE_TGT_SR-1:0] iw_tgt_sr,
  input  logic                   iw_tgt_sr_we,
  input  logic                   iw_mem_mp,
  input  logic [SIZE_DATA-1:0]   iw_mem_data [0:1],
  input  logic [SIZE_DATA-1:0]   iw_result,
  input  logic                   iw_hold,
  output logic [SIZE_ADDR-1:0]   ow_pc,
  output logic [SIZE_DATA-1:0]   ow_instr,
  output logic [SIZE_OPC-1:0]    ow_opc,
  output logic [SIZE_TGT_GP-1:0] ow_tgt_gp,
  output logic                   ow_tgt_gp_we,
  output logic [SIZE_TGT_SR-1:0] ow_tgt_sr,
  output logic                   ow_tgt_sr_we,
  output logic [SIZE_DATA-1:0]   ow_result,
  output logic                   ow_hold,
  output logic                   ow_valid
);

  typedef struct packed {
    logic [SIZE_ADDR-1:0]   pc;
    logic [SIZE_DATA-1:0]   instr;
    logic [SIZE_OPC-1:0]    opc;
    logic [SIZE_TGT_GP-1:0] tgt_gp;
    logic                   tgt_gp_we;
    logic [SIZE_TGT_SR-1:0] tgt_sr;
    logic                   tgt_sr_we;
    logic [SIZE_DATA-1:0]   result;
  } stage_t;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_SKID = 1'b1
  } state_t;

  state_t state_q, state_d;
  stage_t out_q, out_d;
  stage_t skid_q, skid_d;
  logic   valid_q, valid_d;
  stage_t stage_in;
  logic   is_load;
  logic   is_store;

  // Build the resolved stage word. Load data is taken from the memory port in its arrival
  // cycle, so a stall at that point must place this word in the skid buffer.
  always_comb begin
    is_load  = (iw_opc == OPC_RU_LDu);
    is_store = (iw_opc == OPC_RU_STu) || (iw_opc == OPC_IU_STiu) || (iw_opc == OPC_IS_STis);

    stage_in           = '0;
    stage_in.pc        = iw_pc;
    stage_in.instr     = iw_instr;
    stage_in.opc       = iw_opc;
    stage_in.tgt_gp    = iw_tgt_gp;
    stage_in.tgt_sr    = iw_tgt_sr;
    stage_in.tgt_gp_we = iw_tgt_gp_we & ~is_store;
    stage_in.tgt_sr_we = iw_tgt_sr_we & ~is_store;
    if (is_load) begin
      stage_in.result = iw_mem_mp ? iw_mem_data[1] : iw_mem_data[0];
    end else begin
      stage_in.result = iw_result;
    end
  end

  // Next-state logic and datapath steering.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_PASS: begin
        if (iw_hold) begin
          // While stalled, the output register keeps its contents and the new word is stored in the skid buffer.
          skid_d  = stage_in;
          state_d = ST_SKID;
        end else begin
          out_d   = stage_in;
          valid_d = 1'b1;
        end
      end
      ST_SKID: begin
        // Upstream sees ow_hold in this state, so the stage inputs are not used.
        if (!iw_hold) begin
          out_d   = skid_q;
          valid_d = 1'b1;
          state_d = ST_PASS;
        end
      end
      default: begin
        state_d = ST_PASS;
      end
    endcase
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q <= ST_PASS;
      out_q   <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
    end
  end

  assign ow_pc        = out_q.pc;
  assign ow_instr     = out_q.instr;
  assign ow_opc       = out_q.opc;
  assign ow_tgt_gp    = out_q.tgt_gp;
  assign ow_tgt_gp_we = out_q.tgt_gp_we;
  assign ow_tgt_sr    = out_q.tgt_sr;
  assign ow_tgt_sr_we = out_q.tgt_sr_we;
  assign ow_result    = out_q.result;
  assign ow_valid     = valid_q;
  assign ow_hold      = (state_q == ST_SKID);

endmodule

// File: doc/stg5mo.md
STG5MO -- requirements
Module: stg5mo

Interface
REQ-001 iw_clk  in  1  sole clock; all state updates on rising edge.
REQ-002 iw_rst  in  1  asynchronous, active-high reset; clears all state immediately.
REQ-003 iw_pc / ow_pc  in/out  SIZE_ADDR  instruction address, passed through.
REQ-004 iw_instr / ow_instr  in/out  SIZE_DATA  raw instruction word, passed through.
REQ-005 iw_opc / ow_opc  in/out  SIZE_OPC  decoded opcode, passed through.
REQ-006 iw_tgt_gp, iw_tgt_gp_we / ow_tgt_gp, ow_tgt_gp_we  in/out  SIZE_TGT_GP, 1  GP target and write enable.
REQ-007 iw_tgt_sr, iw_tgt_sr_we / ow_tgt_sr, ow_tgt_sr_we  in/out  SIZE_TGT_SR, 1  SR target and write enable.
REQ-008 iw_mem_mp  in  1  memory port-phase bit from the memory-access stage.
REQ-009 iw_mem_data[0:1]  in  2 x SIZE_DATA  read data returned by memory ports 0 and 1, valid only in the arrival cycle.
REQ-010 iw_result / ow_result  in/out  SIZE_DATA  ALU result in; final writeback value out.
REQ-011 iw_hold  in  1  downstream (writeback) stall request.
REQ-012 ow_hold  out  1  stall request to upstream stages.
REQ-013 ow_valid  out  1  output registers carry an instruction not yet consumed.

Function
REQ-014 Port select: iw_mem_mp=0 -> iw_mem_data[0]; iw_mem_mp=1 -> iw_mem_data[1].
REQ-015 Load (iw_opc==OPC_RU_LDu): stage result = selected port data; all other opcodes: stage result = iw_result.
REQ-016 Stores (OPC_RU_STu, OPC_IU_STiu, OPC_IS_STis): stage forces tgt_gp_we=0 and tgt_sr_we=0 regardless of inputs.
REQ-017 Pass-through fields and computed result register with 1-cycle latency when iw_hold=0 and skid is empty.
REQ-018 State machine, 2 states: PASS (skid empty) and SKID (skid holds one captured instruction incl. resolved load data).
REQ-019 PASS, iw_hold=0: output regs <= current stage inputs; ow_valid<=1; stay PASS.
REQ-020 PASS, iw_hold=1: output regs hold; current inputs (with resolved load data) captured into skid; go SKID.
REQ-021 SKID, iw_hold=1: output and skid regs hold; stay SKID; new inputs ignored (upstream is stalled).
REQ-022 SKID, iw_hold=0: output regs <= skid contents; go PASS.
REQ-023 ow_hold = 1 exactly while in SKID (registered, no combinational path from iw_hold).
REQ-024 Load data is sampled only in the arrival cycle; the skid is the sole storage ensuring it is not lost during a stall.
REQ-025 In PASS with iw_hold=1 the skid capture takes priority; the output register contents are not overwritten that cycle.
REQ-026 No arithmetic; all widths follow the size macros; no truncation or extension.

Reset
REQ-027 On iw_rst: all ow_* data outputs = 0, ow_tgt_gp_we=0, ow_tgt_sr_we=0, ow_valid=0, ow_hold=0, skid cleared, state=PASS.
REQ-028 Reset asserted mid-stall (state SKID) discards skid contents; no instruction is replayed after reset release.
REQ-029 First edge after reset release with iw_hold=0 loads inputs normally.

Verification
REQ-030 Load pass: opc=OPC_RU_LDu, mp=0, mem_data[0]=0x1234, mem_data[1]=0xBEEF, tgt_gp_we=1 -> next cycle ow_result=0x1234, ow_tgt_gp_we=1, ow_valid=1.
REQ-031 Port 1 select: same load with mp=1 -> ow_result=0xBEEF.
REQ-032 Store suppress: opc=OPC_IU_STiu, tgt_gp_we=1, tgt_sr_we=1, result=0x55 -> ow_tgt_gp_we=0, ow_tgt_sr_we=0, ow_result=0x55.
REQ-033 Stall with load: output holds instr A; hold=1 while load B (mp=0, data[0]=0x00AA) arrives -> ow_hold=1 next cycle, outputs still A; mem_data changed to 0; hold=0 -> outputs B with ow_result=0x00AA, ow_hold=0.
REQ-034 Long stall: hold=1 for 5 cycles -> state SKID throughout, outputs and ow_hold stable, differing inputs ignored.
REQ-035 Reset in SKID: assert iw_rst while ow_hold=1 -> all outputs 0 asynchronously, ow_hold=0, ow_valid=0; skid instruction never appears.
